imi_cfg_sequencer: RTL

Hardware initiator for the imitator-channel register bus. It takes channel-relative register commands (write or read) from a small command FIFO and drives wr_en/rd_en/reg_addr/wdata with the bus timing the imitator channels expect: the strobe is held for HOLD_CYCLES clocks, with address and data stable one cycle before and throughout. Read data is returned over a valid/ready response port. It sits between the CPU/ROM-based init logic and the imitator channel bank, and replaces software-timed channel initialisation.

---
 rtl/imi_cfg_sequencer.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/imi_cfg_sequencer.sv
// Register-bus initiator for the imitator channel bank: queues channel-relative
// commands and replays them with SETUP/STROBE/GAP bus timing and a read response port.
module imi_cfg_sequencer #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 16'h8000,
    parameter int                    CHNL_W      = 5,
    parameter int                    CHNL_SHIFT  = 6,
    parameter int                    HOLD_CYCLES = 3,
    parameter int                    GAP_CYCLES  = 1,
    parameter int                    FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [CHNL_W-1:0]     cmd_chnl,
    input  logic [CHNL_SHIFT-1:0] cmd_offset,
    input  logic [31:0]           cmd_wdata,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] reg_addr,
    output logic [31:0]           wdata,
    input  logic [31:0]           rdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_data,
    output logic                  busy,
    output logic [15:0]           done_cnt
);

    // state    | meaning
    // S_IDLE   | waiting for a queued command; pops the FIFO head when present
    // S_SETUP  | address/data driven one cycle ahead of the strobe
    // S_STROBE | wr_en or rd_en high for HOLD_CYCLES clocks
    // S_RESP   | read data held until the consumer takes it
    // S_GAP    | GAP_CYCLES idle clocks before the next command
    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_RESP,
        S_GAP
    } state_t;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [31:0]           data;
    } entry_t;

    state_t                state_q, state_d;
    entry_t                mem_q [FIFO_DEPTH];
    entry_t                mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [3:0]            tmr_q, tmr_d;
    logic                  write_q, write_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [31:0]           rsp_data_q, rsp_data_d;
    logic [15:0]           done_cnt_q, done_cnt_d;

    logic                  full, empty, push, pop;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    entry_t                head;

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = cmd_valid && !full;
    assign pop   = (state_q == S_IDLE) && !empty;

    // Address arithmetic is modulo 2^ADDR_WIDTH; a bank near the top of the map wraps to 0.
    assign cmd_addr = BASE_ADDR
                    + (ADDR_WIDTH'(cmd_chnl) << CHNL_SHIFT)
                    + ADDR_WIDTH'(cmd_offset);

    always_comb begin
        state_d     = state_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        tmr_d       = tmr_q;
        write_d     = write_q;
        wr_en_d     = wr_en_q;
        rd_en_d     = rd_en_q;
        reg_addr_d  = reg_addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        done_cnt_d  = done_cnt_q;
        head        = mem_q[rd_ptr_q];

        if (push) begin
            mem_d[wr_ptr_q].write = cmd_write;
            mem_d[wr_ptr_q].addr  = cmd_addr;
            mem_d[wr_ptr_q].data  = cmd_write ? cmd_wdata : 32'h0;
            wr_ptr_d              = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    write_d    = head.write;
                    reg_addr_d = head.addr;
                    wdata_d    = head.data;
                    state_d    = S_SETUP;
                end
            end
            S_SETUP: begin
                wr_en_d = write_q;
                rd_en_d = !write_q;
                tmr_d   = 4'(HOLD_CYCLES - 1);
                state_d = S_STROBE;
            end
            S_STROBE: begin
                if (tmr_q == 4'd0) begin
                    wr_en_d    = 1'b0;
                    rd_en_d    = 1'b0;
                    done_cnt_d = done_cnt_q + 16'd1;
                    if (!write_q) begin
                        rsp_data_d  = rdata;
                        rsp_valid_d = 1'b1;
                        state_d     = S_RESP;
                    end else if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        tmr_d   = 4'(GAP_CYCLES - 1);
                        state_d = S_GAP;
                    end
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (GAP_CYCLES == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        tmr_d   = 4'(GAP_CYCLES - 1);
                        state_d = S_GAP;
                    end
                end
            end
            S_GAP: begin
                if (tmr_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    tmr_d = tmr_q - 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO storage needs no reset: the pointers and count define its contents.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
        if (!reset_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tmr_q       <= '0;
            write_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            reg_addr_q  <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            done_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tmr_q       <= tmr_d;
            write_q     <= write_d;
            wr_en_q     <= wr_en_d;
            rd_en_q     <= rd_en_d;
            reg_addr_q  <= reg_addr_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            done_cnt_q  <= done_cnt_d;
        end
    end

    assign cmd_ready = !full;
    assign wr_en     = wr_en_q;
    assign rd_en     = rd_en_q;
    assign reg_addr  = reg_addr_q;
    assign wdata     = wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign done_cnt  = done_cnt_q;
    assign busy      = (state_q != S_IDLE) || !empty || rsp_valid_q;

endmodule
